// File: rtl/mdu_pkg.sv
// mdu_pkg: op-code encodings, default latencies and the 64-bit {hi,lo} result type
// Latency: n/a (declarations only)
// Backpressure: n/a
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
    // Decode-side "any MDU op" marker; never reaches the execute stage.
    localparam logic [3:0] OP_ANY   = 4'd15;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational {hi,lo} result and mult/div classification for one MDU op
// Latency: 0 cycles (pure combinational); no backpressure, result is consumed by the caller
// Ports: mduop_i/a_i/b_i operands, hi_i/lo_i current HI/LO, res_o result, is_mult_o/is_div_o class.
// Optional ops MADD/MADDU/MSUB/MSUBU are built only when MDU_MADD_EN is defined.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  mduop_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output hilo_t       res_o,
    output logic        is_mult_o,
    output logic        is_div_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] dvsr;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] quo;
    logic [31:0] rem;

    // Operands are widened to 64 bits so the low 64 bits of the product are exact.
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};
    assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};

    // Signed divide is done on magnitudes so 0x80000000 / -1 never hits an
    // overflowing signed divide; negating 0x80000000 wraps back to itself.
    always_comb begin
        signed_div = (mduop_i == OP_DIV);
        num  = (signed_div && a_i[31]) ? (~a_i + 32'd1) : a_i;
        den  = (signed_div && b_i[31]) ? (~b_i + 32'd1) : b_i;
        // Divisor forced non-zero; the result is discarded for divide by zero.
        dvsr = (den == 32'd0) ? 32'd1 : den;
        q_u  = num / dvsr;
        r_u  = num % dvsr;
        quo  = (signed_div && (a_i[31] ^ b_i[31])) ? (~q_u + 32'd1) : q_u;
        rem  = (signed_div && a_i[31]) ? (~r_u + 32'd1) : r_u;
    end

    always_comb begin
        res_o     = {hi_i, lo_i};
        is_mult_o = 1'b0;
        is_div_o  = 1'b0;
        case (mduop_i)
            OP_MULT: begin
                res_o     = prod_s;
                is_mult_o = 1'b1;
            end
            OP_MULTU: begin
                res_o     = prod_u;
                is_mult_o = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                is_div_o = 1'b1;
                // Divide by zero leaves HI/LO untouched at commit.
                if (b_i != 32'd0) begin
                    res_o = {rem, quo};
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                res_o     = {hi_i, lo_i} + prod_s;
                is_mult_o = 1'b1;
            end
            OP_MADDU: begin
                res_o     = {hi_i, lo_i} + prod_u;
                is_mult_o = 1'b1;
            end
            OP_MSUB: begin
                res_o     = {hi_i, lo_i} - prod_s;
                is_mult_o = 1'b1;
            end
            OP_MSUBU: begin
                res_o     = {hi_i, lo_i} - prod_u;
                is_mult_o = 1'b1;
            end
`endif
            default: begin
                res_o     = {hi_i, lo_i};
                is_mult_o = 1'b0;
                is_div_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit owning HI/LO, producer of Busy for hazard stalls
// Latency: mult MULT_CYCLES, div DIV_CYCLES after the start cycle; mfhi/mflo combinational
// Backpressure: Busy (start cycle || count!=0) stalls MDU ops upstream; ops arriving in RUN are ignored
// Ports: clk, reset (sync, active-high), MDUOP/A/B/Req from E stage, Busy and MDUOut outputs.
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (codes 9-12); otherwise those codes act as NONE.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] MDUOut
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] count_q, count_d;
    hilo_t         shadow_q, shadow_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    mdu_state_t    state;
    hilo_t         arith_res;
    logic          is_mult;
    logic          is_div;
    logic          start;

    mdu_arith u_arith (
        .mduop_i   (MDUOP),
        .a_i       (A),
        .b_i       (B),
        .hi_i      (hi_q),
        .lo_i      (lo_q),
        .res_o     (arith_res),
        .is_mult_o (is_mult),
        .is_div_o  (is_div)
    );

    // The counter itself is the state: zero means IDLE.
    assign state = (count_q == '0) ? ST_IDLE : ST_RUN;
    assign start = (is_mult || is_div) && !Req && (state == ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            shadow_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            count_q  <= count_d;
            shadow_q <= shadow_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Next-state logic
    always_comb begin
        count_d  = count_q;
        shadow_d = shadow_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    count_d  = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    shadow_d = arith_res;
                end else if (!Req) begin
                    if (MDUOP == OP_MTHI) hi_d = A;
                    if (MDUOP == OP_MTLO) lo_d = A;
                end
            end
            ST_RUN: begin
                // Req and new ops are ignored here; the op runs to completion.
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    hi_d = shadow_q.hi;
                    lo_d = shadow_q.lo;
                end
            end
            default: begin
                count_d = '0;
            end
        endcase
    end

    // Outputs: reads see only committed HI/LO, never the pending shadow.
    always_comb begin
        Busy = start || (state == ST_RUN);
        case (MDUOP)
            OP_MFHI: MDUOut = hi_q;
            OP_MFLO: MDUOut = lo_q;
            default: MDUOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  MDUOP = OP_NONE;
    logic [31:0] A     = 32'd0;
    logic [31:0] B     = 32'd0;
    logic        Req   = 1'b0;
    logic        Busy;
    logic [31:0] MDUOut;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .MDUOP  (MDUOP),
        .A      (A),
        .B      (B),
        .Req    (Req),
        .Busy   (Busy),
        .MDUOut (MDUOut)
    );

    typedef struct {
        logic        expb;
        logic [31:0] expo;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks  = 0;
    int    errors  = 0;
    int    runleft = 0;

    // Drive one cycle of stimulus and queue the expected Busy/MDUOut for it.
    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic req, input logic rst, input logic expb,
                        input logic [31:0] expo, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        // Hazard logic never presents an op while the unit is running.
        if (runleft != 0) begin
            assert (op == OP_NONE) else $error("op %0d issued while unit running", op);
            runleft--;
        end
        MDUOP = op;
        A     = a;
        B     = b;
        Req   = req;
        reset = rst;
        e.expb = expb;
        e.expo = expo;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic req_run, input string nm);
        step(op, a, b, 1'b0, 1'b0, 1'b1, 32'd0, {nm, "_start"});
        runleft = n;
        for (int i = 0; i < n; i++)
            step(OP_NONE, 32'd0, 32'd0, req_run, 1'b0, 1'b1, 32'd0, {nm, "_run"});
    endtask

    task automatic rd(input logic hi, input logic [31:0] expv, input string nm);
        step(hi ? OP_MFHI : OP_MFLO, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, expv, nm);
    endtask

    task automatic idle_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic req, input string nm);
        step(op, a, b, req, 1'b0, 1'b0, 32'd0, nm);
    endtask

    // Monitor: compares the DUT against each queued expectation mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (Busy !== e.expb) begin
                errors++;
                $display("FAIL %s busy got %0b want %0b", nm, Busy, e.expb);
            end
            checks++;
            if (MDUOut !== e.expo) begin
                errors++;
                $display("FAIL %s mduout got %08h want %08h", nm, MDUOut, e.expo);
            end
        end
    end

    initial begin
        // Reset state
        step(OP_MFHI, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, "rst_hi");
        step(OP_MFLO, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, "rst_lo");

        // MULT -2 * 3: 6 Busy cycles total
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, MC, 1'b0, "mult");
        rd(1'b1, 32'hFFFF_FFFF, "mult_hi");
        rd(1'b0, 32'hFFFF_FFFA, "mult_lo");

        // DIVU 100 / 7 with Req asserted during RUN (must not cancel)
        run_op(OP_DIVU, 32'd100, 32'd7, DC, 1'b1, "divu");
        rd(1'b0, 32'd14, "divu_lo");
        rd(1'b1, 32'd2, "divu_hi");

        // DIV -7 / 2
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, DC, 1'b0, "div");
        rd(1'b0, 32'hFFFF_FFFD, "div_lo");
        rd(1'b1, 32'hFFFF_FFFF, "div_hi");

        // DIV overflow corner
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC, 1'b0, "divovf");
        rd(1'b0, 32'h8000_0000, "divovf_lo");
        rd(1'b1, 32'd0, "divovf_hi");

        // MULTU max * max = 0xFFFFFFFE_00000001
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 1'b0, "multu");
        rd(1'b1, 32'hFFFF_FFFE, "multu_hi");
        rd(1'b0, 32'h0000_0001, "multu_lo");

        // MTHI / MTLO, including a flushed MTLO
        idle_op(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0, "mthi");
        rd(1'b1, 32'h1234_5678, "mthi_rd");
        idle_op(OP_MTLO, 32'h0000_AAAA, 32'd0, 1'b1, "mtlo_req");
        rd(1'b0, 32'h0000_0001, "mtlo_req_rd");
        idle_op(OP_MTLO, 32'd5, 32'd0, 1'b0, "mtlo");
        rd(1'b0, 32'd5, "mtlo_rd");

        // Flushed MULT: no start, HI/LO unchanged
        idle_op(OP_MULT, 32'd7, 32'd9, 1'b1, "mult_req");
        idle_op(OP_NONE, 32'd0, 32'd0, 1'b0, "mult_req_after");
        rd(1'b1, 32'h1234_5678, "mult_req_hi");
        rd(1'b0, 32'd5, "mult_req_lo");

        // Divide by zero: full latency, HI/LO unchanged
        run_op(OP_DIV, 32'd9, 32'd0, DC, 1'b0, "div0");
        rd(1'b0, 32'd5, "div0_lo");
        rd(1'b1, 32'h1234_5678, "div0_hi");

        // Back-to-back: DIVU starts on the first idle cycle after MULT
        run_op(OP_MULT, 32'd6, 32'd7, MC, 1'b0, "b2b_mult");
        run_op(OP_DIVU, 32'd45, 32'd4, DC, 1'b0, "b2b_divu");
        rd(1'b0, 32'd11, "b2b_lo");
        rd(1'b1, 32'd1, "b2b_hi");

        // Reset in the middle of a DIV
        step(OP_DIV, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1, 32'd0, "rstrun_start");
        runleft = DC;
        step(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, "rstrun_run");
        step(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, "rstrun_run");
        step(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0, "rstrun_rst");
        runleft = 0;
        rd(1'b1, 32'd0, "rstrun_hi");
        rd(1'b0, 32'd0, "rstrun_lo");

        // Optional multiply-accumulate codes
        idle_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, "madd_prep");
`ifdef MDU_MADD_EN
        run_op(OP_MADDU, 32'd1, 32'd1, MC, 1'b0, "maddu");
        rd(1'b1, 32'd1, "maddu_hi");
        rd(1'b0, 32'd0, "maddu_lo");
        run_op(OP_MSUB, 32'd1, 32'd1, MC, 1'b0, "msub");
        rd(1'b1, 32'd0, "msub_hi");
        rd(1'b0, 32'hFFFF_FFFF, "msub_lo");
`else
        idle_op(OP_MADDU, 32'd1, 32'd1, 1'b0, "maddu_off");
        idle_op(OP_MADD, 32'd1, 32'd1, 1'b0, "madd_off");
        idle_op(OP_MSUB, 32'd1, 32'd1, 1'b0, "msub_off");
        idle_op(OP_MSUBU, 32'd1, 32'd1, 1'b0, "msubu_off");
        rd(1'b1, 32'd0, "madd_off_hi");
        rd(1'b0, 32'hFFFF_FFFF, "madd_off_lo");
`endif
        idle_op(OP_NONE, 32'd0, 32'd0, 1'b0, "tail");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Execute-stage multiply/divide unit owning the HI/LO registers; it is the producer of the `Busy` signal that the pipeline hazard logic consumes to stall MDU instructions in Decode. It accepts one MDU operation per cycle from the E stage. Mult/div run a fixed multi-cycle latency, and `mfhi`/`mflo` results return combinationally for E-stage forwarding.

## Interface
- `MULT_CYCLES`, default 5: Busy cycles after a mult/multu start.
- `DIV_CYCLES`, default 10: Busy cycles after a div/divu start.
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high.
- `MDUOP` input 4: E-stage operation code, encodings in `mdu_pkg`.
- `A` input 32: rs operand, already forwarded.
- `B` input 32: rt operand, already forwarded.
- `Req` input 1: exception/interrupt flush of the E-stage instruction this cycle.
- `Busy` output 1: MDU occupied. Consumed by hazard logic.
- `MDUOut` output 32: HI for `MFHI`, LO for `MFLO`, otherwise 0.

## Operation
- Op codes:
  - 0 `NONE`, 1 `MULT`, 2 `MULTU`, 3 `DIV`, 4 `DIVU`
  - 5 `MFHI`, 6 `MFLO`, 7 `MTHI`, 8 `MTLO`
  - 9–12 reserved for the configurable ops
  - 15 is the Decode-side "any MDU op" marker and is never presented here.
- Start condition: `MDUOP` ∈ {MULT..DIVU} && `!Req` && `count==0`.
  - On start, load `count` with `MULT_CYCLES` or `DIV_CYCLES`.
  - On start, latch the 64-bit result {hi,lo} into shadow registers.
- Two states:
  - IDLE (`count==0`).
  - RUN (`count!=0`). Decrement every cycle; on the 1→0 transition, commit shadow to HI/LO.
- Arithmetic:
  - MULT: signed 32×32→64, HI=upper, LO=lower. MULTU: unsigned.
  - DIV: LO=quotient, HI=remainder, truncating toward zero; remainder takes the sign of the dividend. DIVU: unsigned.
  - Divide by zero: the op still runs full latency, and HI/LO remain unchanged at commit.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- MTHI/MTLO write HI/LO at the clock edge when `!Req`. They take effect only in IDLE.
- `Req` high: no start, no MTHI/MTLO write. `Req` never cancels an operation already in RUN.
- Any op presented while in RUN is ignored. Hazard logic guarantees none arrive, and the bench asserts this.
- `MDUOut` reads the committed HI/LO. There is no bypass of a pending shadow value.

## Timing
- Reset: `count`=0, HI=0, LO=0, shadows=0. `Busy`=0, `MDUOut`=0.
- Reset mid-RUN aborts the operation. The next cycle is IDLE with HI=LO=0.
- `Busy` = start condition (combinational, in the start cycle) || `count!=0`.
  - A mult holds `Busy` for the start cycle plus `MULT_CYCLES` cycles.
  - A div holds `Busy` for the start cycle plus `DIV_CYCLES` cycles.
- The HI/LO commit is visible on `MDUOut` the cycle after `count` reaches 0, which is also the first cycle with `Busy`=0.
- Back-to-back: a new start is legal on the first cycle with `count==0`.
- MTHI/MTLO: the new value is visible on `MDUOut` the next cycle.

## Configuration
- `MDU_MADD_EN` defined: ops enabled.
  - 9 `MADD`, 10 `MADDU`: {HI,LO} += A×B.
  - 11 `MSUB`, 12 `MSUBU`: {HI,LO} −= A×B.
  - These use `MULT_CYCLES` latency and compute from the current HI/LO at the start cycle.
- `MDU_MADD_EN` undefined: codes 9–12 behave as `NONE`, with no start and `Busy` unaffected.

## Structure
- `mdu_pkg`: op-code localparams, default cycle constants, and a 64-bit result type.
- One sub-module, `mdu_arith`: purely combinational. Takes `MDUOP`, `A`, `B`, HI, LO and produces {hi,lo} plus an `is_mult`/`is_div` classification. The top level owns the counter, the shadow registers and HI/LO.

## Test plan
- MULT A=0xFFFFFFFE(−2) B=3 → `Busy` high for 6 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIVU A=100 B=7 → `Busy` high for 11 cycles; then LO=14, HI=2. DIV A=−7 B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI A=0x12345678 followed by MFHI → `MDUOut`=0x12345678 on the next cycle. MTLO with `Req`=1 → LO unchanged.
- MULT with `Req`=1 → `Busy`=0 throughout and HI/LO unchanged. `reset` at cycle 3 of a DIV → HI=LO=0 and `Busy`=0 the following cycle.
- DIV by 0 after MTLO 5 → full 11-cycle `Busy`, then LO still 5.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then MADDU A=1 B=1 → HI=1, LO=0. Without the macro, the same code → `Busy`=0 and HI/LO unchanged.
